button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
- Parametrised multi-channel front-panel button conditioner. It generalises the single-channel power/reset button filter.
- Per channel: 2-FF synchroniser, counter-based debounce, BMC override, one-cycle press pulse, and long-press detection.
- One channel is routed through a reset-generation FSM. That FSM merges the button with BMC reset and the watchdog, and stretches the PLD reset to a minimum width.
- The block sits between the front-panel pins and the PCH/PLD reset and power-button nets.

Parameters:
NUM_CH, 2, number of button channels (≥1)
DEBOUNCE_CYCLES, 16, consecutive stable synced cycles before the filtered level changes (≥1)
LONG_CYCLES, 64, cycles the filtered level must stay low before o_long_press asserts (> DEBOUNCE_CYCLES)
MIN_RST_CYCLES, 8, minimum cycles o_reset_pld_n stays low after its trigger drops (≥1)
RST_CH, 1, channel index that drives the reset FSM (< NUM_CH)

Ports:
CLK  in  1  single system clock
RESET  in  1  asynchronous, active-high reset
i_btn_n  in  NUM_CH  raw buttons, active low, asynchronous to CLK
i_bmc_force  in  NUM_CH  BMC press request per channel, active high, synchronous
o_btn_n  out  NUM_CH  debounced button level ANDed with ~i_bmc_force, active low
o_press_pulse  out  NUM_CH  one-cycle pulse on each debounced press
o_long_press  out  NUM_CH  high while a debounced press has lasted ≥ LONG_CYCLES
i_bmc_rst  in  1  BMC reset request, level, active high
i_wd_rst  in  1  watchdog expiry pulse, active high
i_wd_nmi_mode  in  1  0 = watchdog expiry causes reset; 1 = watchdog expiry causes NMI
o_nmi  out  1  one-cycle NMI pulse
o_reset_pld_n  out  1  stretched PLD reset, active low

Behaviour:
- Reset values (RESET high, async):
  - Sync flops, filtered levels and o_btn_n: all 1.
  - All counters: 0.
  - o_press_pulse, o_long_press, o_nmi: 0.
  - FSM state: IDLE.
  - o_reset_pld_n: 1.
- Synchroniser: 2 flops per channel; sync value s[i].
- Debounce, per channel, filtered level f[i]:
  - If s[i]==f[i]: cnt cleared.
  - Else if cnt==DEBOUNCE_CYCLES-1: f[i]<=s[i] and cnt<=0.
  - Else: cnt++.
  - Any single cycle of agreement restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: f[i] changes on the (2+DEBOUNCE_CYCLES)th rising edge after the pin change. This holds for a pin change set up before an edge.
- o_btn_n[i] = f[i] & ~i_bmc_force[i]. This output is combinational from registered f; force has zero-cycle latency.
- o_press_pulse[i]: registered; high for exactly 1 cycle, on the cycle after f[i] goes 1→0. i_bmc_force does not generate pulses.
- Long press:
  - While f[i]==0, hold counter increments and saturates at LONG_CYCLES.
  - o_long_press[i] is registered and asserts when the counter reaches LONG_CYCLES.
  - f[i]==1 clears both the counter and o_long_press in the next cycle.
- Reset trigger T (combinational):
  - T = ~f[RST_CH] | i_bmc_rst | (i_wd_rst & ~i_wd_nmi_mode).
  - i_bmc_force does not reach T.
- Reset FSM (o_reset_pld_n registered; low in ASSERT and STRETCH):
  - IDLE: on T go to ASSERT.
  - ASSERT: stay while T; when T drops, go to STRETCH and load scnt=MIN_RST_CYCLES-1.
  - STRETCH:
    - If T, return to ASSERT (re-trigger restarts the stretch).
    - Else if scnt==0, go to IDLE.
    - Else scnt--.
  - o_reset_pld_n falls 1 cycle after T rises. It rises MIN_RST_CYCLES+1 cycles after T falls.
  - A 1-cycle watchdog pulse in reset mode therefore yields MIN_RST_CYCLES+1 low cycles.
- o_nmi: registered copy of i_wd_rst & i_wd_nmi_mode; 1 cycle per input cycle. It does not affect the FSM.
- Simultaneous triggers: they are OR-ed; there is no priority.
- RESET mid-press: all state returns to reset values. A still-held button is re-debounced from scratch after RESET drops. Its press pulse fires again.

Decomposition:
- Shared package btn_pkg holds:
  - reset FSM state enum (IDLE, ASSERT, STRETCH), 2-bit;
  - width helper function for counters.
- Sub-module btn_debounce_ch, generated NUM_CH times. It contains the synchroniser, debounce counter, f, press pulse and long-press logic.
- The top level holds the force masking, trigger OR, reset FSM and NMI flop.

Test Plan:
- Clean press: i_btn_n[1] low at cycle 0 for 100 cycles, defaults.
  - o_btn_n[1]=0 from cycle 18.
  - o_press_pulse[1]=1 only at cycle 19.
  - o_long_press[1]=1 from cycle 83.
  - o_reset_pld_n=0 from cycle 19 to cycle 127; high at 128.
- Glitch rejection: i_btn_n[0] low for 10 cycles, then high.
  - o_btn_n[0], o_press_pulse[0] and o_long_press[0] never change.
  - Bounce train of 15-cycle lows separated by 1-cycle highs: no output change.
- BMC force: i_bmc_force[0]=1 for 5 cycles with button idle.
  - o_btn_n[0]=0 in exactly those 5 cycles.
  - No press pulse; o_reset_pld_n stays 1.
- Watchdog modes:
  - i_wd_nmi_mode=0, 1-cycle i_wd_rst: o_reset_pld_n low for exactly 9 cycles.
  - i_wd_nmi_mode=1: o_nmi high 1 cycle and o_reset_pld_n stays 1.
- Re-trigger: i_bmc_rst high 3 cycles, then low, then high again 4 cycles into STRETCH.
  - o_reset_pld_n stays low continuously.
  - It releases 9 cycles after the second drop.
- Async reset mid-operation: assert RESET while in STRETCH with o_long_press[1]=1.
  - All outputs return to reset values immediately, with no clock needed.
  - After release with the button still held, a new press pulse occurs 19 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared reset-FSM state encoding and counter width helper
package btn_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, STRETCH} rst_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: synchroniser, debounce filter, press pulse and long-press detect for one button
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic f,
  output logic press_pulse,
  output logic long_press
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int LW = cnt_w(LONG_CYCLES);
  logic s1, s, f_q;
  logic [DW-1:0] cnt;
  logic [LW-1:0] hcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s <= 1'b1;
      f <= 1'b1;
      f_q <= 1'b1;
      cnt <= '0;
      hcnt <= '0;
      press_pulse <= 1'b0;
      long_press <= 1'b0;
    end else begin
      s1 <= btn_n;
      s <= s1;
      f_q <= f;
      press_pulse <= f_q & ~f;
      if (s == f) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        f <= s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
      // hold counter saturates so long_press stays up for arbitrarily long presses
      hcnt <= f ? '0 : (hcnt == LW'(LONG_CYCLES) ? hcnt : hcnt + 1'b1);
      long_press <= ~f & (hcnt == LW'(LONG_CYCLES));
    end
  end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: multi-channel front-panel button conditioner with stretched PLD reset and NMI
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES = 64,
  parameter int MIN_RST_CYCLES = 8,
  parameter int RST_CH = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] i_btn_n,
  input  logic [NUM_CH-1:0] i_bmc_force,
  output logic [NUM_CH-1:0] o_btn_n,
  output logic [NUM_CH-1:0] o_press_pulse,
  output logic [NUM_CH-1:0] o_long_press,
  input  logic              i_bmc_rst,
  input  logic              i_wd_rst,
  input  logic              i_wd_nmi_mode,
  output logic              o_nmi,
  output logic              o_reset_pld_n
);
  localparam int SW = cnt_w(MIN_RST_CYCLES);
  logic [NUM_CH-1:0] f;
  logic t;
  rst_state_t state, state_nx;
  logic [SW-1:0] scnt, scnt_nx;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(CLK),
      .rst(RESET),
      .btn_n(i_btn_n[i]),
      .f(f[i]),
      .press_pulse(o_press_pulse[i]),
      .long_press(o_long_press[i])
    );
  end
  assign o_btn_n = f & ~i_bmc_force;
  // BMC force is deliberately kept out of the reset trigger
  assign t = ~f[RST_CH] | i_bmc_rst | (i_wd_rst & ~i_wd_nmi_mode);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      scnt <= '0;
      o_nmi <= 1'b0;
      o_reset_pld_n <= 1'b1;
    end else begin
      state <= state_nx;
      scnt <= scnt_nx;
      o_nmi <= i_wd_rst & i_wd_nmi_mode;
      o_reset_pld_n <= state_nx == IDLE;
    end
  end
  always_comb begin
    state_nx = state;
    scnt_nx = scnt;
    case (state)
      IDLE: state_nx = t ? ASSERT : IDLE;
      ASSERT: if (!t) begin
        state_nx = STRETCH;
        scnt_nx = SW'(MIN_RST_CYCLES - 1);
      end
      STRETCH: if (t) state_nx = ASSERT;
        else if (scnt == '0) state_nx = IDLE;
        else scnt_nx = scnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed vectors with hand-computed expectations for button_event_ctrl
module tb_button_event_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  logic [1:0] i_btn_n, i_bmc_force, o_btn_n, o_press_pulse, o_long_press;
  logic i_bmc_rst, i_wd_rst, i_wd_nmi_mode, o_nmi, o_reset_pld_n;
  int nvec = 0;
  int nerr = 0;

  button_event_ctrl dut (
    .CLK(CLK),
    .RESET(RESET),
    .i_btn_n(i_btn_n),
    .i_bmc_force(i_bmc_force),
    .o_btn_n(o_btn_n),
    .o_press_pulse(o_press_pulse),
    .o_long_press(o_long_press),
    .i_bmc_rst(i_bmc_rst),
    .i_wd_rst(i_wd_rst),
    .i_wd_nmi_mode(i_wd_nmi_mode),
    .o_nmi(o_nmi),
    .o_reset_pld_n(o_reset_pld_n)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_btn"}, o_btn_n, 2'b11);
    chk({tag, "_pulse"}, o_press_pulse, 2'b00);
    chk({tag, "_long"}, o_long_press, 2'b00);
    chk({tag, "_nmi"}, o_nmi, 1'b0);
    chk({tag, "_rstn"}, o_reset_pld_n, 1'b1);
  endtask

  initial begin
    RESET = 1'b1;
    i_btn_n = 2'b11;
    i_bmc_force = 2'b00;
    i_bmc_rst = 1'b0;
    i_wd_rst = 1'b0;
    i_wd_nmi_mode = 1'b0;
    #3;
    chk_reset_vals("rst");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // clean press on the reset channel, pin low for cycles 0..100
    for (int c = 0; c <= 135; c++) begin
      if (c == 0) i_btn_n = 2'b01;
      if (c == 101) i_btn_n = 2'b11;
      #1;
      chk("press_btn", o_btn_n[1], (c >= 18 && c <= 118) ? 1'b0 : 1'b1);
      chk("press_pulse", o_press_pulse[1], c == 19);
      chk("press_long", o_long_press[1], c >= 83 && c <= 119);
      chk("press_rstn", o_reset_pld_n, !(c >= 19 && c <= 127));
      chk("press_ch0", o_btn_n[0], 1'b1);
      step();
    end

    // 10-cycle glitch then a bounce train of 15-cycle lows
    for (int c = 0; c < 120; c++) begin
      i_btn_n[0] = (c < 10) ? 1'b0 : (c < 40) ? 1'b1 : (c >= 104 || (c - 40) % 16 == 15);
      #1;
      chk("glitch_btn", o_btn_n[0], 1'b1);
      chk("glitch_pulse", o_press_pulse[0], 1'b0);
      chk("glitch_long", o_long_press[0], 1'b0);
      step();
    end

    // 16-cycle low is the shortest press that gets through
    for (int c = 0; c < 50; c++) begin
      i_btn_n[0] = c >= 16;
      #1;
      chk("edge_btn", o_btn_n[0], !(c >= 18 && c <= 33));
      chk("edge_pulse", o_press_pulse[0], c == 19);
      chk("edge_rstn", o_reset_pld_n, 1'b1);
      step();
    end

    for (int c = 0; c < 12; c++) begin
      i_bmc_force[0] = c >= 3 && c < 8;
      #1;
      chk("force_btn", o_btn_n[0], !(c >= 3 && c < 8));
      chk("force_pulse", o_press_pulse[0], 1'b0);
      chk("force_rstn", o_reset_pld_n, 1'b1);
      step();
    end

    for (int c = 0; c < 15; c++) begin
      i_wd_rst = c == 0;
      #1;
      chk("wdrst_rstn", o_reset_pld_n, !(c >= 1 && c <= 9));
      chk("wdrst_nmi", o_nmi, 1'b0);
      step();
    end

    i_wd_nmi_mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      i_wd_rst = c == 0;
      #1;
      chk("wdnmi_nmi", o_nmi, c == 1);
      chk("wdnmi_rstn", o_reset_pld_n, 1'b1);
      step();
    end
    i_wd_nmi_mode = 1'b0;

    for (int c = 0; c < 23; c++) begin
      i_bmc_rst = c < 3 || c == 8 || c == 9;
      #1;
      chk("retrig_rstn", o_reset_pld_n, !(c >= 1 && c <= 18));
      step();
    end

    // long press on ch0, then catch the FSM in STRETCH and hit RESET mid-cycle
    for (int c = 0; c <= 90; c++) begin
      i_btn_n[0] = 1'b0;
      #1;
      if (c == 90) chk("hold_long", o_long_press[0], 1'b1);
      step();
    end
    for (int c = 0; c <= 4; c++) begin
      i_bmc_rst = c == 0;
      #1;
      if (c == 4) begin
        chk("pre_rst_rstn", o_reset_pld_n, 1'b0);
        chk("pre_rst_long", o_long_press[0], 1'b1);
      end
      step();
    end
    #2 RESET = 1'b1;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    for (int c = 0; c < 26; c++) begin
      #1;
      chk("rearm_btn", o_btn_n[0], c < 18);
      chk("rearm_pulse", o_press_pulse[0], c == 19);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
